// File: rtl/vocab_encoder.sv
// vocab_encoder: dictionary tokenizer walking a zero-terminated input against a zero-terminated vocabulary,
// emitting one code per token (first or longest match) on a valid/ready stream.
module vocab_encoder #(
  parameter int DATA_WIDTH     = 8,
  parameter int VOC_ADDR_WIDTH = 4,
  parameter int IN_ADDR_WIDTH  = 4,
  parameter int CODE_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  input  logic                      mode,
  input  logic                      voc_we,
  input  logic [VOC_ADDR_WIDTH-1:0] voc_addr,
  input  logic [DATA_WIDTH-1:0]     voc_din,
  input  logic                      in_we,
  input  logic [IN_ADDR_WIDTH-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0]     in_din,
  output logic                      code_valid,
  output logic [CODE_WIDTH-1:0]     code,
  input  logic                      code_ready,
  output logic                      busy,
  output logic                      done,
  output logic [IN_ADDR_WIDTH:0]    n_codes
);
  localparam logic [CODE_WIDTH-1:0] UNK = '1;
  typedef enum logic [2:0] {IDLE, START, SCAN, SKIP, EMIT, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] voc_mem [2**VOC_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] in_mem [2**IN_ADDR_WIDTH];
  logic [IN_ADDR_WIDTH:0] pos, i, best_len, pi, step;
  logic [VOC_ADDR_WIDTH-1:0] av;
  logic [CODE_WIDTH-1:0] k, k_next, best_code;
  logic [DATA_WIDTH-1:0] v, c;
  logic mode_r, last_av, k_full;
  assign busy       = state inside {START, SCAN, SKIP, EMIT};
  assign done       = state == DONE;
  assign code_valid = state == EMIT;
  assign code       = code_valid ? (best_len != '0 ? best_code : UNK) : '0;
  assign pi         = pos + i;
  assign v          = voc_mem[av];
  assign c          = pi[IN_ADDR_WIDTH] ? '0 : in_mem[pi[IN_ADDR_WIDTH-1:0]];
  assign last_av    = av == '1;
  assign k_next     = k + 1'b1;
  assign k_full     = k_next == UNK;
  assign step       = best_len != '0 ? best_len : (IN_ADDR_WIDTH+1)'(1);
  always_ff @(posedge clk) begin
    if (voc_we && !busy) voc_mem[voc_addr] <= voc_din;
    if (in_we && !busy) in_mem[in_addr] <= in_din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos       <= '0;
      av        <= '0;
      i         <= '0;
      k         <= '0;
      best_code <= '0;
      best_len  <= '0;
      mode_r    <= 1'b0;
      n_codes   <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (cs) begin
          pos      <= '0;
          av       <= '0;
          i        <= '0;
          k        <= '0;
          best_len <= '0;
          n_codes  <= '0;
          mode_r   <= mode;
          state    <= START;
        end
        START: state <= (pos[IN_ADDR_WIDTH] || in_mem[pos[IN_ADDR_WIDTH-1:0]] == '0) ? DONE : SCAN;
        SCAN: begin
          if (v == '0) begin
            if (i == '0) state <= EMIT;
            else if (!mode_r) begin
              best_code <= k;
              best_len  <= i;
              state     <= EMIT;
            end else begin
              // longest match: strictly longer wins, so ties keep the lower code
              if (i > best_len) begin
                best_code <= k;
                best_len  <= i;
              end
              av <= av + 1'b1;
              k  <= k_next;
              i  <= '0;
              if (last_av || k_full) state <= EMIT;
            end
          end else if (v == c) begin
            av <= av + 1'b1;
            i  <= i + 1'b1;
            if (last_av) state <= EMIT;
          end else begin
            av    <= av + 1'b1;
            state <= last_av ? EMIT : SKIP;
          end
        end
        SKIP: begin
          av <= av + 1'b1;
          if (last_av) state <= EMIT;
          else if (v == '0) begin
            k     <= k_next;
            i     <= '0;
            state <= k_full ? EMIT : SCAN;
          end
        end
        EMIT: if (code_ready) begin
          pos      <= pos + step;
          n_codes  <= n_codes + 1'b1;
          av       <= '0;
          i        <= '0;
          k        <= '0;
          best_len <= '0;
          state    <= START;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vocab_encoder.sv
// tb_vocab_encoder: directed and randomized checks of vocab_encoder against a string-matching reference model.
module tb_vocab_encoder;
  logic clk = 0, rst_n = 0, cs = 0, mode = 0;
  logic voc_we = 0, in_we = 0, code_ready = 0;
  logic [3:0] voc_addr = 0, in_addr = 0;
  logic [7:0] voc_din = 0, in_din = 0;
  logic code_valid, busy, done;
  logic [7:0] code;
  logic [4:0] n_codes;
  logic [7:0] vm [16];
  logic [7:0] im [16];
  logic [7:0] got_q[$], exp_q[$];
  int n_assert = 0, n_fail = 0;

  vocab_encoder dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .mode(mode),
    .voc_we(voc_we), .voc_addr(voc_addr), .voc_din(voc_din),
    .in_we(in_we), .in_addr(in_addr), .in_din(in_din),
    .code_valid(code_valid), .code(code), .code_ready(code_ready),
    .busy(busy), .done(done), .n_codes(n_codes)
  );

  always #5 clk = ~clk;

  // '|' stands for the 0 terminator in the directed strings
  function automatic void put(input bit to_voc, input string s);
    for (int a = 0; a < 16; a++) if (to_voc) vm[a] = 8'h0; else im[a] = 8'h0;
    for (int a = 0; a < s.len() && a < 16; a++) begin
      if (to_voc) vm[a] = (s[a] == 8'h7c) ? 8'h0 : s[a];
      else im[a] = (s[a] == 8'h7c) ? 8'h0 : s[a];
    end
  endfunction

  // Reference: list the entries, then at each position try every entry as a whole string
  function automatic void model(input bit m);
    int st[$], ln[$];
    int a, p, best, bl;
    bit ok;
    exp_q.delete();
    a = 0;
    while (a < 16 && vm[a] != 0) begin
      st.push_back(a);
      while (a < 16 && vm[a] != 0) a++;
      ln.push_back(a - st[st.size()-1]);
      a++;
    end
    p = 0;
    while (p < 16 && im[p] != 0) begin
      best = -1;
      bl = 0;
      for (int e = 0; e < st.size(); e++) begin
        ok = 1;
        for (int j = 0; j < ln[e]; j++) if (p + j >= 16 || im[p+j] != vm[st[e]+j]) ok = 0;
        if (ok && (m ? ln[e] > bl : best < 0)) begin
          best = e;
          bl = ln[e];
        end
      end
      exp_q.push_back(best < 0 ? 8'hFF : 8'(best));
      p += bl > 0 ? bl : 1;
    end
  endfunction

  function automatic bit q_eq();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (got_q[j]) if (got_q[j] !== exp_q[j]) return 0;
    return 1;
  endfunction

  task automatic load();
    for (int a = 0; a < 16; a++) begin
      voc_we = 1; in_we = 1;
      voc_addr = 4'(a); in_addr = 4'(a);
      voc_din = vm[a]; in_din = im[a];
      @(negedge clk);
    end
    voc_we = 0; in_we = 0;
  endtask

  task automatic run(input bit m, input int gap, input bit poke);
    int cyc, wait_c;
    bit holding;
    logic [7:0] held;
    got_q.delete();
    holding = 0; wait_c = 0; cyc = 0; held = 0;
    mode = m; cs = 1;
    @(negedge clk);
    cs = 0; mode = 0;
    while (!done && cyc < 3000) begin
      code_ready = 0; voc_we = 0;
      if (code_valid) begin
        if (holding) begin
          n_assert++;
          if (code !== held) begin n_fail++; $display("FAIL hold_stable code=%h required=%h", code, held); end
        end else begin
          holding = 1; held = code; wait_c = 0;
          if (poke) begin voc_we = 1; voc_addr = 0; voc_din = 8'h7a; end
        end
        if (wait_c >= gap) begin
          code_ready = 1;
          got_q.push_back(code);
          holding = 0;
        end
        wait_c++;
      end
      @(negedge clk);
      cyc++;
    end
    code_ready = 0; voc_we = 0;
    n_assert++;
    if (cyc >= 3000) begin n_fail++; $display("FAIL run_timeout cycles=%0d limit=3000", cyc); end
  endtask

  task automatic test_reset();
    n_assert++;
    if (code_valid !== 0 || code !== 0 || busy !== 0 || done !== 0 || n_codes !== 0) begin
      n_fail++;
      $display("FAIL reset_state valid=%b code=%h busy=%b done=%b n=%0d required all 0", code_valid, code, busy, done, n_codes);
    end
  endtask

  task automatic test_first_match();
    put(1, "a|ab||"); put(0, "ab|"); load();
    run(0, 0, 0);
    exp_q = '{8'h00, 8'hFF};
    n_assert++;
    if (!q_eq()) begin n_fail++; $display("FAIL first_match codes=%p required=%p", got_q, exp_q); end
    n_assert++;
    if (done !== 1 || n_codes !== 2) begin n_fail++; $display("FAIL first_match_end done=%b n=%0d required 1/2", done, n_codes); end
  endtask

  task automatic test_longest_match();
    run(1, 0, 0);
    exp_q = '{8'h01};
    n_assert++;
    if (!q_eq()) begin n_fail++; $display("FAIL longest_match codes=%p required=%p", got_q, exp_q); end
    n_assert++;
    if (done !== 1 || n_codes !== 1) begin n_fail++; $display("FAIL longest_match_end done=%b n=%0d required 1/1", done, n_codes); end
  endtask

  task automatic test_empty_vocab();
    put(1, "|"); put(0, "xyz|"); load();
    run(0, 1, 0);
    exp_q = '{8'hFF, 8'hFF, 8'hFF};
    n_assert++;
    if (!q_eq() || n_codes !== 3) begin n_fail++; $display("FAIL empty_vocab codes=%p n=%0d required=%p n=3", got_q, n_codes, exp_q); end
  endtask

  task automatic test_empty_input();
    put(1, "a||"); put(0, "|"); load();
    cs = 1;
    @(negedge clk);
    cs = 0;
    n_assert++;
    if (busy !== 1 || done !== 0) begin n_fail++; $display("FAIL empty_input_start busy=%b done=%b required 1/0", busy, done); end
    @(negedge clk);
    n_assert++;
    if (done !== 1 || busy !== 0 || n_codes !== 0 || code_valid !== 0) begin
      n_fail++;
      $display("FAIL empty_input_done done=%b busy=%b n=%0d valid=%b required 1/0/0/0", done, busy, n_codes, code_valid);
    end
  endtask

  task automatic test_backpressure();
    put(1, "ab|a|b||"); put(0, "aab|"); load();
    run(0, 5, 1);
    exp_q = '{8'h01, 8'h00};
    n_assert++;
    if (!q_eq()) begin n_fail++; $display("FAIL backpressure codes=%p required=%p", got_q, exp_q); end
    n_assert++;
    if (n_codes !== 2) begin n_fail++; $display("FAIL backpressure_count n=%0d required=2", n_codes); end
  endtask

  task automatic test_pos_wrap();
    put(1, "a||");
    for (int a = 0; a < 16; a++) im[a] = 8'h61;
    load();
    run(0, 0, 0);
    exp_q.delete();
    for (int a = 0; a < 16; a++) exp_q.push_back(8'h00);
    n_assert++;
    if (!q_eq() || n_codes !== 16 || done !== 1) begin n_fail++; $display("FAIL pos_wrap codes=%p n=%0d done=%b required 16 zeros n=16", got_q, n_codes, done); end
  endtask

  task automatic test_reset_mid();
    int seen, c;
    put(1, "a|ab||"); put(0, "ab|"); load();
    cs = 1;
    @(negedge clk);
    cs = 0; seen = 0; c = 0;
    while (seen < 2 && c < 200) begin
      @(negedge clk);
      c++;
      code_ready = 0;
      if (code_valid) begin seen++; code_ready = (seen == 1); end
    end
    n_assert++;
    if (seen < 2) begin n_fail++; $display("FAIL reset_mid_reach seen=%0d required=2", seen); end
    rst_n = 0;
    #1;
    n_assert++;
    if (code_valid !== 0 || busy !== 0 || done !== 0 || n_codes !== 0 || code !== 0) begin
      n_fail++;
      $display("FAIL reset_mid valid=%b busy=%b done=%b n=%0d code=%h required all 0", code_valid, busy, done, n_codes, code);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 0, 0);
    exp_q = '{8'h00, 8'hFF};
    n_assert++;
    if (!q_eq() || n_codes !== 2) begin n_fail++; $display("FAIL reset_restart codes=%p n=%0d required=%p n=2", got_q, n_codes, exp_q); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int used, n, l, len;
      bit m;
      used = 0;
      for (int a = 0; a < 16; a++) begin vm[a] = 0; im[a] = 0; end
      n = $urandom_range(0, 5);
      for (int e = 0; e < n; e++) begin
        l = $urandom_range(1, 3);
        if (used + l + 2 > 16) break;
        for (int j = 0; j < l; j++) vm[used+j] = 8'(8'h61 + $urandom_range(0, 2));
        used += l + 1;
      end
      len = $urandom_range(0, 16);
      for (int j = 0; j < len; j++) im[j] = 8'(8'h61 + $urandom_range(0, 3));
      m = 1'($urandom_range(0, 1));
      load();
      model(m);
      run(m, $urandom_range(0, 2), 0);
      n_assert++;
      if (!q_eq() || n_codes !== 5'(exp_q.size()) || done !== 1) begin
        n_fail++;
        $display("FAIL random_%0d mode=%b codes=%p n=%0d required=%p", t, m, got_q, n_codes, exp_q);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    @(negedge clk);
    test_first_match();
    test_longest_match();
    test_empty_vocab();
    test_empty_input();
    test_backpressure();
    test_pos_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
